// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    localparam int unsigned UART_OVS    = 16;
    localparam int unsigned UART_MID    = 7;
    localparam int unsigned UART_LAST   = 15;
    localparam int unsigned UART_SCNT_W = $clog2(UART_OVS);

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW + 1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input sync, 16x oversampled frame FSM and receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd port and PARITY state).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WID    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [DIV_WID-1:0] div_factor,
    input  logic               uart_rxd,
`ifdef UART_RX_PARITY_EN
    input  logic               parity_odd,
`endif
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    input  logic               err_clr,
    output logic               frame_err,
    output logic               parity_err,
    output logic               overrun,
    output logic               rx_busy
);

    localparam logic [UART_SCNT_W-1:0] SMID  = UART_SCNT_W'(UART_MID);
    localparam logic [UART_SCNT_W-1:0] SLAST = UART_SCNT_W'(UART_LAST);

    logic               sync1_q, sync2_q, rxd_prev_q;
    logic               rxd_s, rxd_fall;
    logic [DIV_WID-1:0] tcnt_q, tcnt_d;
    logic               tick;

    uart_rx_state_e         state_q, state_d;
    logic [UART_SCNT_W-1:0] scnt_q, scnt_d;
    logic [2:0]             bidx_q, bidx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   push, frame_set;
    logic                   frame_q, overrun_q;
    logic                   fifo_full, fifo_empty, pop, overrun_set;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync1_q    <= uart_rxd;
            sync2_q    <= sync1_q;
            rxd_prev_q <= sync2_q;
        end
    end

    assign rxd_s    = sync2_q;
    assign rxd_fall = rxd_prev_q && !rxd_s;

    assign tick   = (tcnt_q == '0);
    assign tcnt_d = tick ? div_factor : tcnt_q - DIV_WID'(1);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) tcnt_q <= '0;
        else          tcnt_q <= tcnt_d;
    end

`ifdef UART_RX_PARITY_EN
    logic parity_set, parity_q;
`endif

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bidx_d    = bidx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        if (tick && state_q != IDLE && state_q != WAIT_HIGH) scnt_d = scnt_q + UART_SCNT_W'(1);

        case (state_q)
            IDLE: begin
                // Start edge is taken on any cycle so the mid-bit point is tick-accurate.
                if (rxd_fall) begin
                    state_d = START;
                    scnt_d  = '0;
                end
            end
            START: begin
                if (tick && scnt_q == SMID) begin
                    if (!rxd_s) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bidx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && scnt_q == SLAST) begin
                    shreg_d = {rxd_s, shreg_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && scnt_q == SLAST) begin
                    parity_set = (rxd_s != (^shreg_q ^ parity_odd));
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && scnt_q == SLAST) begin
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
        end
    end

    assign pop         = rx_valid && rx_ready;
    assign overrun_set = push && fifo_full && !pop;

    // Sticky flags: a new event outranks a clear in the same cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            frame_q   <= frame_set || (frame_q && !err_clr);
            overrun_q <= overrun_set || (overrun_q && !err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) parity_q <= 1'b0;
        else          parity_q <= parity_set || (parity_q && !err_clr);
    end
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .hclk   (hclk),
        .hresetn(hresetn),
        .push   (push),
        .wdata  (shreg_q),
        .pop    (pop),
        .rdata  (rx_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table plus timed corner sequences, scoreboard on pops.
module tb_uart_rx;

    localparam int unsigned DIV_WID    = 4;
    localparam int unsigned FIFO_DEPTH = 4;

    logic               hclk = 1'b0;
    logic               hresetn = 1'b0;
    logic [DIV_WID-1:0] div_factor = '0;
    logic               uart_rxd = 1'b1;
    logic               rx_ready = 1'b0;
    logic               err_clr = 1'b0;
    logic [7:0]         rx_data;
    logic               rx_valid, frame_err, parity_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic               parity_odd = 1'b0;
    logic               par_flip = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    always #5 hclk = ~hclk;

    uart_rx #(
        .DIV_WID   (DIV_WID),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .div_factor(div_factor),
        .uart_rxd  (uart_rxd),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, and the parity bit when enabled.
    task automatic send_head(input logic [7:0] d);
        int bt;
        bt = 16 * (int'(div_factor) + 1);
        uart_rxd = 1'b0;
        cyc(bt);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            cyc(bt);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = ^d ^ parity_odd ^ par_flip;
        cyc(bt);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int bt;
        bt = 16 * (int'(div_factor) + 1);
        send_head(d);
        uart_rxd = stop;
        cyc(bt);
        uart_rxd = 1'b1;
        cyc(bt);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
    endtask

    // Scoreboard: every pop must match the oldest expected byte.
    always @(negedge hclk) begin
        logic [7:0] exp_b;
        if (hresetn && rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
            end else begin
                exp_b = sb.pop_front();
                check("pop_data", 32'(rx_data), 32'(exp_b));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    typedef struct {
        logic [7:0]         data;
        logic               stop;
        logic [DIV_WID-1:0] div;
        logic               exp_push;
        logic               exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{data: 8'h55, stop: 1'b1, div: 4'd0, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, div: 4'd0, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, div: 4'd1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hA5, stop: 1'b1, div: 4'd2, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, div: 4'd0, exp_push: 1'b0, exp_ferr: 1'b1};
        vecs[5] = '{data: 8'h81, stop: 1'b1, div: 4'd3, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[6] = '{data: 8'h7E, stop: 1'b0, div: 4'd1, exp_push: 1'b0, exp_ferr: 1'b1};

        cyc(3);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        hresetn = 1'b1;
        cyc(5);
        check("idle_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        // 0x55 at div 0: rx_valid rises exactly one cycle after the stop sample.
        send_head(8'h55);
        uart_rxd = 1'b1;
        cyc(10);
        check("stop_sample_valid", 32'(rx_valid), 32'd0);
        check("stop_sample_busy", 32'(rx_busy), 32'd1);
        cyc(1);
        check("push_valid", 32'(rx_valid), 32'd1);
        check("push_data", 32'(rx_data), 32'h55);
        check("push_busy", 32'(rx_busy), 32'd0);
        check("push_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        sb.push_back(8'h55);
        rx_ready = 1'b1;
        cyc(20);
        check("drain_55", 32'(sb.size()), 32'd0);

        // 3-cycle glitch: START samples high and falls back to IDLE.
        uart_rxd = 1'b0;
        cyc(3);
        uart_rxd = 1'b1;
        cyc(2);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        cyc(10);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_no_push", 32'(rx_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            div_factor = vecs[i].div;
            cyc(20);
            if (vecs[i].exp_push) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            cyc(4);
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'd0);
            check($sformatf("vec%0d_delivered", i), 32'(sb.size()), 32'd0);
            pulse_clr();
            check($sformatf("vec%0d_clr", i), 32'(frame_err), 32'd0);
        end
        div_factor = '0;
        cyc(20);

        // 0xA3 with stop held low two bit times; err_clr collides with the set.
        send_head(8'hA3);
        uart_rxd = 1'b0;
        cyc(10);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("ferr_set_wins", 32'(frame_err), 32'd1);
        check("ferr_no_push", 32'(rx_valid), 32'd0);
        cyc(16);
        check("ferr_wait_high", 32'(rx_busy), 32'd1);
        cyc(5);
        uart_rxd = 1'b1;
        cyc(4);
        check("ferr_back_idle", 32'(rx_busy), 32'd0);
        pulse_clr();
        check("ferr_clr", 32'(frame_err), 32'd0);

        // Overrun: five bytes into a 4-deep FIFO with no consumer.
        rx_ready = 1'b0;
        cyc(16);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == 4) check("ovr_before", 32'(overrun), 32'd0);
        end
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        cyc(8);
        check("ovr_drained", 32'(rx_valid), 32'd0);
        check("ovr_sb_empty", 32'(sb.size()), 32'd0);
        pulse_clr();
        check("ovr_clr", 32'(overrun), 32'd0);

        // Push and pop in the same cycle while full: accepted, no overrun.
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        send_head(8'h15);
        uart_rxd = 1'b1;
        cyc(10);
        sb.push_back(8'h15);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        check("full_pushpop_ovr", 32'(overrun), 32'd0);
        check("full_pushpop_head", 32'(rx_data), 32'h12);
        cyc(24);
        rx_ready = 1'b1;
        cyc(8);
        check("full_pushpop_sb", 32'(sb.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        par_flip   = 1'b1;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        cyc(4);
        check("par_err_set", 32'(parity_err), 32'd1);
        check("par_err_delivered", 32'(sb.size()), 32'd0);
        pulse_clr();
        check("par_err_clr", 32'(parity_err), 32'd0);
        par_flip = 1'b0;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        cyc(4);
        check("par_even_ok", 32'(parity_err), 32'd0);
        parity_odd = 1'b1;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        cyc(4);
        check("par_odd_ok", 32'(parity_err), 32'd0);
        parity_odd = 1'b0;
`endif

        // Reset mid-DATA with a byte buffered and frame_err set.
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        send_frame(8'h3C, 1'b0);
        cyc(4);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_ferr", 32'(frame_err), 32'd1);
        uart_rxd = 1'b0;
        cyc(16 * 4);
        check("pre_rst_busy", 32'(rx_busy), 32'd1);
        hresetn = 1'b0;
        #2;
        check("rst_outputs",
              32'({rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy}), 32'd0);
        uart_rxd = 1'b1;
        cyc(3);
        hresetn = 1'b1;
        cyc(5);
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        cyc(4);
        check("post_rst_c3", 32'(sb.size()), 32'd0);
        check("final_parity_err", 32'(parity_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
